// File: rtl/inv_sub_bytes_serial_if.sv
// rtl/inv_sub_bytes_serial_if.sv - block-in / block-out handshake bundle for the inverse SubBytes engine
interface inv_sub_bytes_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] block;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] new_block;

  modport master (
    output in_valid, block, round_key, out_ready,
    input  in_ready, out_valid, new_block
  );

  modport slave (
    input  in_valid, block, round_key, out_ready,
    output in_ready, out_valid, new_block
  );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// rtl/inv_sub_bytes_serial.sv - serial AES inverse SubBytes with optional AddRoundKey, BYTES_PER_CYCLE lookups per clock
module inv_sub_bytes_serial #(
  parameter int BYTES_PER_CYCLE = 4,
  parameter int ADD_KEY         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inv_sub_bytes_serial_if.slave bus
);
  localparam int CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Row r holds inv_sbox[16r .. 16r+15]; entry x sits at bits {~x, 3'b111} -: 8.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [127:0]  blk_q;
  logic [127:0]  key_q;
  logic [127:0]  result_q;
  logic [127:0]  sub_next;
  logic          out_valid_q;
  logic          last_chunk;
  int            base;

  assign base       = BYTES_PER_CYCLE * int'(cnt);
  assign last_chunk = (cnt == CW'(CHUNKS - 1));

  always_comb begin
    sub_next = result_q;
    for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
      sub_next[8*(base+b) +: 8] = inv_sbox(blk_q[8*(base+b) +: 8])
                                ^ ((ADD_KEY != 0) ? key_q[8*(base+b) +: 8] : 8'h00);
    end
  end

  // DONE spends its first cycle settling out_valid; the handshake is honoured only once it is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            blk_q <= bus.block;
            key_q <= bus.round_key;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          result_q <= sub_next;
          if (last_chunk) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.new_block = result_q;
endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// tb/tb_inv_sub_bytes_serial.sv - directed + random checks of inv_sub_bytes_serial against a GF(2^8)-derived model
module tb_inv_sub_bytes_serial;
  localparam int NDUT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid_a  [NDUT];
  logic [127:0] block_a     [NDUT];
  logic [127:0] key_a       [NDUT];
  logic         out_ready_a [NDUT];
  logic         in_ready_a  [NDUT];
  logic         out_valid_a [NDUT];
  logic [127:0] new_block_a [NDUT];

  // Instances 0..4 sweep BPC 1,2,4,8,16 with the key enabled; instance 5 is BPC 4 with ADD_KEY=0.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int BPC = (g == 5) ? 4 : (1 << g);
    localparam int ADD = (g == 5) ? 0 : 1;
    inv_sub_bytes_serial_if bus ();
    assign bus.in_valid    = in_valid_a[g];
    assign bus.block       = block_a[g];
    assign bus.round_key   = key_a[g];
    assign bus.out_ready   = out_ready_a[g];
    assign in_ready_a[g]   = bus.in_ready;
    assign out_valid_a[g]  = bus.out_valid;
    assign new_block_a[g]  = bus.new_block;
    inv_sub_bytes_serial #(.BYTES_PER_CYCLE(BPC), .ADD_KEY(ADD)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sbox_m  [256];
  logic [7:0] isbox_m [256];

  function automatic int bpc_of(input int idx);
    return (idx == 5) ? 4 : (1 << idx);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_model();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x]  = s;
      isbox_m[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] key, input bit add);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = isbox_m[blk[8*i +: 8]] ^ (add ? key[8*i +: 8] : 8'h00);
    return r;
  endfunction

  function automatic logic [127:0] fwd_sub(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m[blk[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block, scrambles the inputs afterwards, and waits for out_valid; leaves the DUT in DONE.
  task automatic run_block(input int idx, input logic [127:0] blk, input logic [127:0] key,
                           output logic [127:0] res, output int lat);
    int w = 0;
    res = 'x;
    lat = -1;
    while (!in_ready_a[idx] && w < 100) begin step(); w++; end
    if (w >= 100) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid_a[idx] = 1'b1;
    block_a[idx]    = blk;
    key_a[idx]      = key;
    step();
    in_valid_a[idx] = 1'b0;
    block_a[idx]    = rnd128();
    key_a[idx]      = rnd128();
    check("busy_in_ready", in_ready_a[idx], 0);
    lat = 0;
    while (!out_valid_a[idx] && lat < 100) begin step(); lat++; end
    if (lat >= 100) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    res = new_block_a[idx];
  endtask

  task automatic consume(input int idx);
    out_ready_a[idx] = 1'b1;
    step();
    out_ready_a[idx] = 1'b0;
    check("idle_after_handshake", {in_ready_a[idx], out_valid_a[idx]}, 2'b10);
  endtask

  initial begin
    logic [127:0] res, blk, key, orig;
    int lat;

    for (int i = 0; i < NDUT; i++) begin
      in_valid_a[i]  = 1'b0;
      block_a[i]     = '0;
      key_a[i]       = '0;
      out_ready_a[i] = 1'b0;
    end
    build_model();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check("reset_in_ready", in_ready_a[i], 1);
      check("reset_out_valid", out_valid_a[i], 0);
      check("reset_new_block", new_block_a[i], 0);
    end

    // 1: inv_sbox(63)=00 everywhere, key 0.
    run_block(2, {16{8'h63}}, '0, res, lat);
    check("t1_result", res, 0);
    check("t1_latency", lat, 16 / bpc_of(2) + 1);
    consume(2);

    // 2: known table points plus random filler bytes.
    blk = rnd128();
    blk[7:0] = 8'h00; blk[15:8] = 8'h63; blk[23:16] = 8'h7c; blk[127:120] = 8'h16;
    run_block(2, blk, '0, res, lat);
    check("t2_model", res, model(blk, '0, 1'b0));
    check("t2_byte0", res[7:0], 8'h52);
    check("t2_byte1", res[15:8], 8'h00);
    check("t2_byte2", res[23:16], 8'h01);
    check("t2_byte15", res[127:120], 8'hff);
    consume(2);

    // 3: key passes through when the substitution yields zero; ignored when ADD_KEY=0.
    key = 128'h000102030405060708090a0b0c0d0e0f;
    run_block(2, {16{8'h63}}, key, res, lat);
    check("t3_key_added", res, key);
    consume(2);
    run_block(5, {16{8'h63}}, key, res, lat);
    check("t3_key_ignored", res, 0);
    consume(5);

    // 4: backpressure holds DONE for 20 cycles.
    blk = rnd128();
    key = rnd128();
    run_block(2, blk, key, res, lat);
    for (int c = 0; c < 20; c++) begin
      step();
      check("t4_hold", {out_valid_a[2], in_ready_a[2], new_block_a[2]}, {2'b10, model(blk, key, 1'b1)});
    end
    consume(2);

    // 5: reset in the 2nd BUSY cycle of the 16-chunk instance; in_valid during reset is ignored.
    in_valid_a[0] = 1'b1;
    block_a[0]    = rnd128();
    step();
    in_valid_a[0] = 1'b0;
    step();
    rst = 1'b1;
    in_valid_a[2] = 1'b1;
    block_a[2]    = rnd128();
    step();
    rst = 1'b0;
    in_valid_a[2] = 1'b0;
    for (int i = 0; i < NDUT; i++)
      check("t5_after_reset", {in_ready_a[i], out_valid_a[i], new_block_a[i]}, {2'b10, 128'h0});
    step();
    check("t5_no_accept_in_reset", in_ready_a[2], 1);
    blk = rnd128();
    key = rnd128();
    run_block(0, blk, key, res, lat);
    check("t5_recover", res, model(blk, key, 1'b1));
    consume(0);

    // Random keyed blocks on both key settings.
    for (int n = 0; n < 20; n++) begin
      for (int idx = 2; idx <= 5; idx += 3) begin
        blk = rnd128();
        key = rnd128();
        run_block(idx, blk, key, res, lat);
        check("rand_keyed", res, model(blk, key, idx != 5));
        consume(idx);
      end
    end

    // 6: round trip through the forward S-box for every BPC.
    for (int idx = 0; idx < 5; idx++) begin
      for (int n = 0; n < 400; n++) begin
        orig = rnd128();
        run_block(idx, fwd_sub(orig), '0, res, lat);
        check("t6_roundtrip", res, orig);
        check("t6_latency", lat, 16 / bpc_of(idx) + 1);
        out_ready_a[idx] = 1'b1;
        step();
        out_ready_a[idx] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
